// File: rtl/dmem_req_ctrl_pkg.sv
// Shared encodings for the data-memory request controller: bus size codes and FSM states.
package dmem_req_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_req_ctrl_align.sv
// Combinational misalignment detector: flags AdEL/AdES for half/word accesses off their
// natural boundary and for stores whose lane formatter produced no byte enables.
module dmem_align_check
  import dmem_req_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                req_valid,
  input  logic                req_wr,
  input  logic [1:0]          req_size,
  input  logic [1:0]          addr_lo,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                addr_err
);

  logic half_bad;
  logic word_bad;
  logic strb_bad;

  assign half_bad = (req_size == SZ_HALF) & addr_lo[0];
  assign word_bad = (req_size == SZ_WORD) & (addr_lo != 2'b00);
  assign strb_bad = req_wr & (req_wstrb == '0);
  assign addr_err = req_valid & (half_bad | word_bad | strb_bad);

endmodule

// File: rtl/dmem_req_ctrl.sv
// M-stage data-memory controller: one SRAM-like req/addr_ok/data_ok transaction per load/store.
// Optional macro DMEM_PERF_CNT_EN adds completed-access and stall-cycle counters.
module dmem_req_ctrl
  import dmem_req_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  input  logic                req_wr_i,
  input  logic [1:0]          req_size_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wstrb_i,
  input  logic                hold_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                addr_err_o,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W/8-1:0] data_wstrb,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]         perf_acc_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  state_e state;
  logic   cancel;
  logic   issue;

  dmem_align_check #(.DATA_W(DATA_W)) u_align (
    .req_valid (req_valid_i),
    .req_wr    (req_wr_i),
    .req_size  (req_size_i),
    .addr_lo   (req_addr_i[1:0]),
    .req_wstrb (req_wstrb_i),
    .addr_err  (addr_err_o)
  );

  assign issue = req_valid_i & ~addr_err_o & ~flush_i;

  // Stall is released in the data_ok cycle itself so the stage advances with the fresh data.
  always_comb begin
    stall_o = 1'b0;
    unique case (state)
      S_IDLE:  stall_o = issue;
      S_ADDR:  stall_o = 1'b1;
      S_DATA:  stall_o = ~(data_data_ok & ~cancel);
      default: stall_o = 1'b0;
    endcase
    if (rst) stall_o = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cancel     <= 1'b0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wdata <= '0;
      data_wstrb <= '0;
      rdata_o    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (issue) begin
            data_req   <= 1'b1;
            data_wr    <= req_wr_i;
            data_size  <= req_size_i;
            data_addr  <= req_addr_i;
            data_wdata <= req_wdata_i;
            data_wstrb <= req_wr_i ? req_wstrb_i : '0;
            cancel     <= 1'b0;
            state      <= S_ADDR;
          end
        end
        // The request stays up until accepted even when flushed; the bus cannot take it back.
        S_ADDR: begin
          if (flush_i) cancel <= 1'b1;
          if (data_addr_ok) begin
            data_req <= 1'b0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (data_data_ok) begin
            if (~cancel & ~data_wr) rdata_o <= data_rdata;
            state  <= (hold_i & ~cancel) ? S_DONE : S_IDLE;
            cancel <= 1'b0;
          end else if (flush_i) begin
            cancel <= 1'b1;
          end
        end
        S_DONE: begin
          if (~hold_i | flush_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_acc_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if ((state == S_DATA) & data_data_ok & ~cancel) perf_acc_cnt <= perf_acc_cnt + 32'd1;
      if (stall_o) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Self-checking bench for dmem_req_ctrl: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the access lifecycle.
`timescale 1ns/1ps
module tb_dmem_req_ctrl;
  import dmem_req_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_wr_i, hold_i, flush_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic        stall_o, addr_err_o;
  logic [31:0] rdata_o;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] perf_acc_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  dmem_req_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_wr_i(req_wr_i), .req_size_i(req_size_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .hold_i(hold_i), .flush_i(flush_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .addr_err_o(addr_err_o),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
`ifdef DMEM_PERF_CNT_EN
    , .perf_acc_cnt(perf_acc_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level model: an access is pending until its data phase ends, then optionally
  // held as a finished result while the stage is frozen.
  bit          mPend, mAcc, mCancel, mHeld;
  logic        mWr;
  logic [1:0]  mSize;
  logic [31:0] mAddr, mWdata, mRdata;
  logic [3:0]  mWstrb;
  logic [31:0] mPerfAcc, mPerfStall;

  // Bus responder: addr_ok after aDly waiting cycles, data_ok dDly cycles after acceptance.
  int aDly, dDly, phaseCnt;
  bit randDly;

  int stallSeen, reqSeen, hsSeen;
  logic sErr, sStall, sReq;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPend = 0; mAcc = 0; mCancel = 0; mHeld = 0;
    mWr = 0; mSize = 0; mAddr = 0; mWdata = 0; mWstrb = 0; mRdata = 0;
    mPerfAcc = 0; mPerfStall = 0; phaseCnt = 0;
  endtask

  task automatic applyStimulus(input logic v, input logic wr, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                               input logic h, input logic f, input logic [31:0] rb);
    logic expErr, issue, expReq, expStall, aOk, dOk;
    @(negedge clk);
    req_valid_i = v; req_wr_i = wr; req_size_i = sz; req_addr_i = a;
    req_wdata_i = wd; req_wstrb_i = ws; hold_i = h; flush_i = f; data_rdata = rb;
    aOk = mPend & ~mAcc & (phaseCnt == aDly);
    dOk = mPend & mAcc & (phaseCnt == dDly);
    data_addr_ok = aOk;
    data_data_ok = dOk;
    #1;
    expErr   = v & (((sz == SZ_HALF) & a[0]) | ((sz == SZ_WORD) & (a[1:0] != 2'b00)) |
                    (wr & (ws == 4'b0000)));
    issue    = ~mPend & ~mHeld & v & ~expErr & ~f;
    expReq   = mPend & ~mAcc;
    expStall = mHeld ? 1'b0 : (mPend ? ~(mAcc & dOk & ~mCancel) : issue);
    checkOutput("addr_err_o", {31'b0, addr_err_o}, {31'b0, expErr});
    checkOutput("stall_o", {31'b0, stall_o}, {31'b0, expStall});
    checkOutput("data_req", {31'b0, data_req}, {31'b0, expReq});
    checkOutput("rdata_o", rdata_o, mRdata);
    if (expReq) begin
      checkOutput("data_wr", {31'b0, data_wr}, {31'b0, mWr});
      checkOutput("data_size", {30'b0, data_size}, {30'b0, mSize});
      checkOutput("data_addr", data_addr, mAddr);
      checkOutput("data_wdata", data_wdata, mWdata);
      checkOutput("data_wstrb", {28'b0, data_wstrb}, {28'b0, mWstrb});
    end
`ifdef DMEM_PERF_CNT_EN
    checkOutput("perf_acc_cnt", perf_acc_cnt, mPerfAcc);
    checkOutput("perf_stall_cnt", perf_stall_cnt, mPerfStall);
`endif
    sErr = addr_err_o; sStall = stall_o; sReq = data_req;
    stallSeen += int'(stall_o);
    reqSeen   += int'(data_req);
    hsSeen    += int'(data_req & aOk);
    @(posedge clk);
    mPerfStall += {31'b0, expStall};
    if (mHeld) begin
      if (~h | f) mHeld = 0;
    end else if (mPend) begin
      if (~mAcc) begin
        if (f) mCancel = 1;
        if (aOk) begin mAcc = 1; phaseCnt = 0; end
        else phaseCnt++;
      end else if (dOk) begin
        if (~mCancel & ~mWr) mRdata = rb;
        if (~mCancel) mPerfAcc++;
        mHeld = h & ~mCancel;
        mCancel = 0;
        mPend = 0;
      end else begin
        if (f) mCancel = 1;
        phaseCnt++;
      end
    end else if (issue) begin
      mPend = 1; mAcc = 0; mCancel = 0;
      mWr = wr; mSize = sz; mAddr = a; mWdata = wd; mWstrb = wr ? ws : 4'b0000;
      phaseCnt = 0;
      if (randDly) begin
        aDly = $urandom_range(0, 3);
        dDly = $urandom_range(0, 3);
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clearSeen();
    stallSeen = 0; reqSeen = 0; hsSeen = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_stall"}, {31'b0, stall_o}, 32'd0);
    checkOutput({tag, "_req"}, {31'b0, data_req}, 32'd0);
    checkOutput({tag, "_wr"}, {31'b0, data_wr}, 32'd0);
    checkOutput({tag, "_size"}, {30'b0, data_size}, 32'd0);
    checkOutput({tag, "_addr"}, data_addr, 32'd0);
    checkOutput({tag, "_wdata"}, data_wdata, 32'd0);
    checkOutput({tag, "_wstrb"}, {28'b0, data_wstrb}, 32'd0);
    checkOutput({tag, "_rdata"}, rdata_o, 32'd0);
    checkOutput({tag, "_err"}, {31'b0, addr_err_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid_i = 0; req_wr_i = 0; req_size_i = 0; req_addr_i = 0; req_wdata_i = 0;
    req_wstrb_i = 0; hold_i = 0; flush_i = 0; data_addr_ok = 0; data_data_ok = 0;
    data_rdata = 0; randDly = 0; aDly = 0; dDly = 0;
    modelReset();
    clearSeen();
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;

    // Aligned word load: addr_ok one cycle late, data_ok right after acceptance.
    aDly = 1; dDly = 0; clearSeen();
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, SZ_WORD, 32'h10, 0, 0, 0, 0, 32'hDEADBEEF);
    idleCycles(2);
    checkOutput("load_stall_cycles", stallSeen, 32'd3);
    checkOutput("load_handshakes", hsSeen, 32'd1);
    checkOutput("load_rdata", rdata_o, 32'hDEADBEEF);

    // Byte store at offset 3 with a slow address phase.
    aDly = 4; dDly = 0; clearSeen();
    for (int i = 0; i < 7; i++)
      applyStimulus(1, 1, SZ_BYTE, 32'h13, 32'h5A5A5A5A, 4'b1000, 0, 0, 32'h11111111);
    idleCycles(2);
    checkOutput("store_req_cycles", reqSeen, 32'd5);
    checkOutput("store_rdata_kept", rdata_o, 32'hDEADBEEF);

    // Misaligned accesses never reach the bus.
    clearSeen();
    applyStimulus(1, 0, SZ_WORD, 32'h102, 0, 0, 0, 0, 0);
    checkOutput("misal_word_err", {31'b0, sErr}, 32'd1);
    checkOutput("misal_word_stall", {31'b0, sStall}, 32'd0);
    applyStimulus(1, 1, SZ_HALF, 32'h104, 32'h00FF00FF, 4'b0000, 0, 0, 0);
    checkOutput("misal_strb_err", {31'b0, sErr}, 32'd1);
    idleCycles(2);
    checkOutput("misal_req_cycles", reqSeen, 32'd0);

    // Load finishing under hold: result parked, no re-issue while frozen.
    aDly = 0; dDly = 0; clearSeen();
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, SZ_WORD, 32'h20, 0, 0, 1, 0, 32'hCAFEF00D);
    checkOutput("hold_stall_low", {31'b0, sStall}, 32'd0);
    applyStimulus(1, 0, SZ_WORD, 32'h20, 0, 0, 0, 0, 32'hCAFEF00D);
    idleCycles(2);
    checkOutput("hold_stall_cycles", stallSeen, 32'd2);
    checkOutput("hold_req_cycles", reqSeen, 32'd1);
    checkOutput("hold_rdata", rdata_o, 32'hCAFEF00D);

    // Flush during the address phase: request drains, read data is dropped.
    aDly = 2; dDly = 1; clearSeen();
    applyStimulus(1, 0, SZ_WORD, 32'h30, 0, 0, 0, 0, 32'h12345678);
    applyStimulus(1, 0, SZ_WORD, 32'h30, 0, 0, 0, 1, 32'h12345678);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678);
    checkOutput("flush_stall_cycles", stallSeen, 32'd6);
    checkOutput("flush_req_cycles", reqSeen, 32'd3);
    checkOutput("flush_rdata_kept", rdata_o, 32'hCAFEF00D);

    // Reset asserted while the data phase is outstanding.
    aDly = 0; dDly = 3;
    applyStimulus(1, 0, SZ_WORD, 32'h40, 0, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, SZ_WORD, 32'h40, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    req_valid_i = 0; data_addr_ok = 0; data_data_ok = 0;
    rst = 1'b1;
    #1;
    checkResetOutputs("midrst");
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    aDly = 0; dDly = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, SZ_WORD, 32'h44, 0, 0, 0, 0, 32'h0BADCAFE);
    idleCycles(1);
    checkOutput("after_rst_rdata", rdata_o, 32'h0BADCAFE);

    // Randomized traffic against the model.
    randDly = 1;
    for (int i = 0; i < 3000; i++) begin
      logic        v, wr, h, f;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [3:0]  ws;
      v  = ($urandom_range(0, 3) != 0);
      wr = $urandom_range(0, 1) == 1;
      sz = 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      ws = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) != 0 && ws == 4'b0000) ws = 4'b0001;
      h  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 15) == 0);
      applyStimulus(v, wr, sz, a, $urandom, ws, h, f, $urandom);
    end
    randDly = 0;
    aDly = 0; dDly = 0;
    idleCycles(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/dmem_req_ctrl.md
Name: dmem_req_ctrl

Overview:
Memory-stage controller that sequences one data-memory access per load/store instruction onto the SRAM-like data bus (req/addr_ok/data_ok handshake).
- Takes the byte-lane enables and replicated write data from the store-lane formatter.
- Stalls the pipeline while an access is outstanding and buffers read data until the stage advances.
- Detects misaligned accesses and drains cancelled (flushed) transactions without issuing duplicates.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte lanes = DATA_W/8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid_i  in  1  M-stage instruction is a load/store
req_wr_i  in  1  1 = store, 0 = load
req_size_i  in  2  0 = byte, 1 = half, 2 = word
req_addr_i  in  ADDR_W  effective address
req_wdata_i  in  DATA_W  lane-replicated store data
req_wstrb_i  in  DATA_W/8  store byte enables (0 = misaligned store)
hold_i  in  1  M stage cannot advance this cycle (other stall source)
flush_i  in  1  exception/flush; kill current M-stage access
stall_o  out  1  pipeline stall request
rdata_o  out  DATA_W  load data for M stage
addr_err_o  out  1  misaligned access (AdEL/AdES), combinational
data_req  out  1  bus request
data_wr  out  1  bus write
data_size  out  2  bus size
data_addr  out  ADDR_W  bus address
data_wdata  out  DATA_W  bus write data
data_wstrb  out  DATA_W/8  bus byte enables
data_addr_ok  in  1  bus accepted address
data_data_ok  in  1  bus data phase complete
data_rdata  in  DATA_W  bus read data

Behaviour:
- Reset (async, rst=1): state=IDLE; data_req=0; data_wr=0; data_size=0; data_addr=0; data_wdata=0; data_wstrb=0; rdata_o=0; cancel=0; stall_o=0.
- Misalignment, combinational:
  - addr_err_o = req_valid_i & ((size==1 & addr[0]) | (size==2 & addr[1:0]!=0) | (req_wr_i & wstrb==0)).
  - A misaligned access never issues a bus request.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If req_valid_i & ~addr_err_o & ~flush_i: register wr/size/addr/wdata/wstrb (loads drive wstrb=0), go ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - data_req=1; registered request fields are held stable.
  - On data_addr_ok: go DATA.
  - data_req is never retracted before addr_ok, even on flush.
- DATA:
  - Wait for data_data_ok. data_ok in the same cycle as addr_ok is not legal on this bus and is ignored in ADDR.
  - On data_ok with cancel=0 and load: rdata_o <= data_rdata.
  - Next state on data_ok: DONE if hold_i & ~cancel, else IDLE. cancel clears.
- DONE:
  - Result is held and no re-issue occurs while hold_i=1.
  - On ~hold_i: go IDLE.
  - flush_i in DONE: go IDLE.
- Flush:
  - flush_i in ADDR or DATA sets cancel=1. The transaction drains, read data is discarded, and no DONE is entered.
  - flush_i in IDLE suppresses issue.
- stall_o is combinational:
  - 1 in IDLE when an issue occurs.
  - 1 in ADDR.
  - 1 in DATA unless data_ok & ~cancel.
  - 1 while cancel=1 until drain completes.
  - 0 in DONE.
- Latency: minimum 3 cycles from req_valid_i to stall release (IDLE→ADDR with addr_ok→DATA with data_ok). Store behaviour is identical; rdata_o is unchanged on stores.
- A new request in the cycle DONE/DATA exits to IDLE is taken on the following cycle (one access per instruction, no back-to-back bypass).

Optional Feature:
DMEM_PERF_CNT_EN
- Defined:
  - Adds outputs perf_acc_cnt[31:0] (+1 per completed non-cancelled access) and perf_stall_cnt[31:0] (+1 per cycle stall_o=1).
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - FSM state codes S_IDLE/S_ADDR/S_DATA/S_DONE (2-bit).
- One natural sub-module, dmem_align_check: combinational addr_err_o from size/addr/wr/wstrb.

Test Plan:
- Aligned load, addr=0x00000010 word, addr_ok 1 cycle after req, data_ok next cycle with rdata=0xDEADBEEF, hold_i=0 → stall_o high 3 cycles, rdata_o=0xDEADBEEF, return to IDLE, exactly one data_req handshake.
- Byte store, addr=0x...03, wstrb=4'b1000, wdata=0x5A5A5A5A, addr_ok delayed 4 cycles → data_req held 5 cycles with stable addr/wstrb/wdata, data_wr=1, rdata_o unchanged.
- Misaligned: word load at 0x...02 and half store with wstrb=0 → addr_err_o=1 same cycle, data_req never asserted, stall_o=0.
- Load completes with hold_i=1 for 3 cycles → DONE, stall_o=0, rdata_o held, no second data_req; on hold_i=0 return to IDLE.
- flush_i during ADDR → data_req held until addr_ok, data_ok with rdata=0x12345678 discarded (rdata_o keeps previous value), stall_o released only after data_ok.
- Assert rst mid-DATA → all outputs 0 immediately; after release, new word load completes normally.
